// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares one register-file write port among ALU (0), load (1) and MUL/DIV (2).
// Optional forwarding taps from the registered write stage are built when WB_FWD_EN is defined.

module wb_starve_cnt #(
  parameter int STARVE_MAX = 4,
  parameter int CW         = $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic grant,
  output logic promoted
);
  localparam logic [CW-1:0] MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt <= '0;
    else if (!valid || grant) cnt <= '0;
    else if (cnt != MAX)     cnt <= cnt + CW'(1);
  end

  assign promoted = (cnt == MAX);
endmodule

module wb_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req_valid,
  input  logic [14:0]       req_rd,
  input  logic [3*XLEN-1:0] req_data,
  output logic [2:0]        req_ready,
  output logic              reg_write,
  output logic [4:0]        write_reg,
  output logic [XLEN-1:0]   write_data,
`ifdef WB_FWD_EN
  input  logic [4:0]        fwd_rs1,
  input  logic [4:0]        fwd_rs2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [XLEN-1:0]   fwd1_data,
  output logic [XLEN-1:0]   fwd2_data,
`endif
  output logic              wb_conflict
);
  localparam int NUM_REQ = 3;

  logic [NUM_REQ-1:0][4:0]      rd_a;
  logic [NUM_REQ-1:0][XLEN-1:0] data_a;
  logic [NUM_REQ-1:0]           promoted;
  logic [NUM_REQ-1:0]           grant;
  logic [4:0]                   sel_rd;
  logic [XLEN-1:0]              sel_data;

  assign rd_a   = req_rd;
  assign data_a = req_data;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    wb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .valid    (req_valid[i]),
      .grant    (req_ready[i]),
      .promoted (promoted[i])
    );
  end

  // Starved requesters win first (lowest index), then load > mul/div > alu.
  always_comb begin
    grant = '0;
    if (|(promoted & req_valid)) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (promoted[i] && req_valid[i] && grant == '0) grant[i] = 1'b1;
    end else if (req_valid[1]) grant = 3'b010;
    else if (req_valid[2])     grant = 3'b100;
    else if (req_valid[0])     grant = 3'b001;
  end

  // No grants while reset is held so nothing is consumed that will not be written.
  assign req_ready = rst ? grant : '0;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) begin
        sel_rd   = rd_a[i];
        sel_data = data_a[i];
      end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      reg_write <= 1'b0;
      if (|req_ready) begin
        // x0 destinations still consume the slot but never write.
        reg_write  <= (sel_rd != 5'd0);
        write_reg  <= sel_rd;
        write_data <= sel_data;
      end
    end
  end

  assign wb_conflict = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2]) |
                       (req_valid[1] & req_valid[2]);

`ifdef WB_FWD_EN
  assign fwd1_hit  = reg_write && (write_reg == fwd_rs1) && (fwd_rs1 != 5'd0);
  assign fwd2_hit  = reg_write && (write_reg == fwd_rs2) && (fwd_rs2 != 5'd0);
  assign fwd1_data = fwd1_hit ? write_data : '0;
  assign fwd2_data = fwd2_hit ? write_data : '0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized + directed bench for wb_port_arbiter against a per-cycle behavioural arbitration model.
// Forwarding checks are compiled in when WB_FWD_EN is defined.

module tb_wb_port_arbiter;
  localparam int XLEN = 32;
  localparam int SMAX = 4;

  logic              clk;
  logic              rst;
  logic [2:0]        req_valid;
  logic [14:0]       req_rd;
  logic [3*XLEN-1:0] req_data;
  logic [2:0]        req_ready;
  logic              reg_write;
  logic [4:0]        write_reg;
  logic [XLEN-1:0]   write_data;
  logic              wb_conflict;
`ifdef WB_FWD_EN
  logic [4:0]        fwd_rs1, fwd_rs2;
  logic              fwd1_hit, fwd2_hit;
  logic [XLEN-1:0]   fwd1_data, fwd2_data;
`endif

  wb_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
`ifdef WB_FWD_EN
    .fwd_rs1     (fwd_rs1),
    .fwd_rs2     (fwd_rs2),
    .fwd1_hit    (fwd1_hit),
    .fwd2_hit    (fwd2_hit),
    .fwd1_data   (fwd1_data),
    .fwd2_data   (fwd2_data),
`endif
    .wb_conflict (wb_conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Requester side: pending request held until granted.
  bit            pv  [3];
  logic [4:0]    prd [3];
  logic [31:0]   pd  [3];
  // Reference model state.
  int            mcnt[3];
  bit            exp_rw;
  logic [4:0]    exp_wr;
  logic [31:0]   exp_wd;
  bit            known;   // write_reg/write_data content is unambiguous

  task automatic pack();
    for (int i = 0; i < 3; i++) begin
      req_valid[i]          = pv[i];
      req_rd[i*5 +: 5]      = prd[i];
      req_data[i*32 +: 32]  = pd[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      pv[i]   = 0;
    end
    exp_rw = 0; exp_wr = '0; exp_wd = '0; known = 1;
  endtask

  // One clock: called at posedge+1. Applies inputs, checks combinational outputs mid-cycle,
  // advances the model, checks registered outputs just after the next edge.
  task automatic tick(output logic [2:0] rdy_seen, output logic conf_seen);
    int pick;
    int order[3];
    logic [2:0] g;
    order = '{1, 2, 0};
    pack();
    pick = -1;
    for (int i = 0; i < 3; i++)
      if (pv[i] && mcnt[i] >= SMAX && pick < 0) pick = i;
    for (int k = 0; k < 3; k++)
      if (pick < 0 && pv[order[k]]) pick = order[k];
    g = (pick >= 0) ? (3'b001 << pick) : 3'b000;
    #3;
    rdy_seen  = req_ready;
    conf_seen = wb_conflict;
    chk("ready", req_ready, g);
    chk("conflict", wb_conflict, (int'(pv[0]) + int'(pv[1]) + int'(pv[2])) > 1);
    for (int i = 0; i < 3; i++)
      if (!pv[i] || i == pick) mcnt[i] = 0;
      else if (mcnt[i] < SMAX) mcnt[i]++;
    if (pick >= 0) begin
      exp_rw = (prd[pick] != 0);
      exp_wr = prd[pick];
      exp_wd = pd[pick];
      known  = (prd[pick] != 0);
    end else exp_rw = 0;
    @(posedge clk);
    #1;
    chk("reg_write", reg_write, exp_rw);
    if (known) begin
      chk("write_reg", write_reg, exp_wr);
      chk("write_data", write_data, exp_wd);
    end
`ifdef WB_FWD_EN
    begin
      bit h1, h2;
      h1 = exp_rw && exp_wr == fwd_rs1 && fwd_rs1 != 0;
      h2 = exp_rw && exp_wr == fwd_rs2 && fwd_rs2 != 0;
      chk("fwd1_hit", fwd1_hit, h1);
      chk("fwd2_hit", fwd2_hit, h2);
      chk("fwd1_data", fwd1_data, h1 ? exp_wd : 32'h0);
      chk("fwd2_data", fwd2_data, h2 ? exp_wd : 32'h0);
    end
`endif
    for (int i = 0; i < 3; i++)
      if (g[i]) pv[i] = 0;
  endtask

  logic [2:0] rs;
  logic       cf;

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1; prd[i] = 5'(i + 1); pd[i] = 32'hA0 + i;
    end
`ifdef WB_FWD_EN
    fwd_rs1 = '0; fwd_rs2 = '0;
`endif
    // Reset with every requester asserting.
    rst = 1'b0;
    pack();
    #12;
    chk("rst_reg_write", reg_write, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    model_reset();
    pack();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single ALU request.
    pv[0] = 1; prd[0] = 5; pd[0] = 32'hDEADBEEF;
    tick(rs, cf);
    chk("t2_ready", rs, 3'b001);
    chk("t2_write_reg", write_reg, 5);
    chk("t2_write_data", write_data, 32'hDEADBEEF);
    tick(rs, cf);
    chk("t2_idle_write", reg_write, 0);

    // All three at once: load, mul/div, alu.
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1; prd[i] = 5'(10 + i); pd[i] = 32'h1000 + i;
    end
    tick(rs, cf); chk("t3_g1", rs, 3'b010); chk("t3_c1", cf, 1); chk("t3_w1", reg_write, 1);
    tick(rs, cf); chk("t3_g2", rs, 3'b100); chk("t3_c2", cf, 1); chk("t3_w2", reg_write, 1);
    tick(rs, cf); chk("t3_g3", rs, 3'b001); chk("t3_c3", cf, 0); chk("t3_w3", reg_write, 1);

    // Starvation: ALU waits while loads keep arriving.
    pv[0] = 1; prd[0] = 9; pd[0] = 32'h99;
    for (int c = 1; c <= SMAX + 1; c++) begin
      pv[1] = 1; prd[1] = 5'(20 + c); pd[1] = 32'(c);
      tick(rs, cf);
      chk($sformatf("t4_cyc%0d", c), rs, (c == SMAX + 1) ? 3'b001 : 3'b010);
    end
    pv[1] = 1; pv[0] = 1; prd[0] = 4;
    tick(rs, cf);
    chk("t4_cleared", rs, 3'b010);
    tick(rs, cf);
    chk("t4_after", rs, 3'b001);

    // Write to x0 takes the slot but never writes.
    pv[1] = 1; prd[1] = 0; pd[1] = 32'h1234;
    tick(rs, cf);
    chk("t5_ready", rs, 3'b010);
    chk("t5_no_write", reg_write, 0);

`ifdef WB_FWD_EN
    pv[2] = 1; prd[2] = 7; pd[2] = 32'h55;
    fwd_rs1 = 7; fwd_rs2 = 0;
    tick(rs, cf);
    chk("t6_hit1", fwd1_hit, 1);
    chk("t6_data1", fwd1_data, 32'h55);
    chk("t6_hit2", fwd2_hit, 0);
`endif

    // Random traffic with a mid-request reset.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++)
        if (!pv[i] && ($urandom % 3) != 0) begin
          pv[i]  = 1;
          prd[i] = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pd[i]  = $urandom;
        end
`ifdef WB_FWD_EN
      fwd_rs1 = 5'($urandom_range(0, 31));
      fwd_rs2 = exp_wr;
`endif
      if (c == 300) begin
        pack();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_write", reg_write, 0);
        chk("mid_rst_reg", write_reg, 0);
        chk("mid_rst_data", write_data, 0);
        model_reset();
        pack();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_write", reg_write, 0);
      end else begin
        tick(rs, cf);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
